// File: rtl/id_ex_ctrl_stage_if.sv
// ID/EX stage bus: IF/ID-side handshake in, registered EX-side control out.
// The master modport is the stage itself; the slave modport is its environment.
interface id_ex_ctrl_stage_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
);
  logic [31:0]        instr_i;
  logic               id_valid_i;
  logic               id_ready_o;
  logic               flush_i;
  logic               ex_ready_i;
  logic               ex_valid_o;
  logic               ex_regdst_o;
  logic               ex_alusrc_o;
  logic               ex_branch_o;
  logic               ex_memread_o;
  logic               ex_memwrite_o;
  logic               ex_regwrite_o;
  logic               ex_readdatareg_o;
  logic               ex_jal_o;
  logic [ALUOP_W-1:0] ex_aluop_o;
  logic [1:0]         ex_brtype_o;
  logic [1:0]         ex_memtoreg_o;
  logic [1:0]         ex_jjr_o;
  logic [REG_AW-1:0]  ex_rs_o;
  logic [REG_AW-1:0]  ex_rt_o;
  logic [REG_AW-1:0]  ex_rd_o;
  logic               ex_illegal_o;
  logic               hazard_o;

  modport master (
    input  instr_i, id_valid_i, flush_i, ex_ready_i,
    output id_ready_o, ex_valid_o, ex_regdst_o, ex_alusrc_o, ex_branch_o,
           ex_memread_o, ex_memwrite_o, ex_regwrite_o, ex_readdatareg_o,
           ex_jal_o, ex_aluop_o, ex_brtype_o, ex_memtoreg_o, ex_jjr_o,
           ex_rs_o, ex_rt_o, ex_rd_o, ex_illegal_o, hazard_o
  );

  modport slave (
    output instr_i, id_valid_i, flush_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_regdst_o, ex_alusrc_o, ex_branch_o,
           ex_memread_o, ex_memwrite_o, ex_regwrite_o, ex_readdatareg_o,
           ex_jal_o, ex_aluop_o, ex_brtype_o, ex_memtoreg_o, ex_jjr_o,
           ex_rs_o, ex_rt_o, ex_rd_o, ex_illegal_o, hazard_o
  );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// Registered MIPS main decoder with valid/ready flow control, load-use interlock and flush.
// Optional stall/bubble counters are built when ID_STALL_CNT_EN is defined.
module id_ex_ctrl_stage #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  id_ex_ctrl_stage_if.master bus
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        bubble_cnt_o
`endif
);

  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic               branch;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               readdatareg;
    logic               jal;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         brtype;
    logic [1:0]         memtoreg;
    logic [1:0]         jjr;
    logic               illegal;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
  } entry_t;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [REG_AW-1:0]  rs_f, rt_f, rd_f;
  logic [ALUOP_W-1:0] aluop_f;
  logic [2:0]         aluop3;
  logic               rs_used, rt_used;
  entry_t             dec_base, dec;
  entry_t             entry_q, entry_d;
  logic               valid_q, valid_d;
  logic               advance, hazard;
  logic               unused_shamt;

  assign op           = bus.instr_i[31:26];
  assign funct        = bus.instr_i[5:0];
  assign unused_shamt = &{1'b0, bus.instr_i[10:6]};

  // Register indices and ALU op are zero-extended or truncated to the configured widths.
  if (REG_AW > 5) begin : g_idx_ext
    assign rs_f = {{(REG_AW-5){1'b0}}, bus.instr_i[25:21]};
    assign rt_f = {{(REG_AW-5){1'b0}}, bus.instr_i[20:16]};
    assign rd_f = {{(REG_AW-5){1'b0}}, bus.instr_i[15:11]};
  end else begin : g_idx_trunc
    assign rs_f = bus.instr_i[21 +: REG_AW];
    assign rt_f = bus.instr_i[16 +: REG_AW];
    assign rd_f = bus.instr_i[11 +: REG_AW];
  end

  if (ALUOP_W > 3) begin : g_alu_ext
    assign aluop_f = {{(ALUOP_W-3){1'b0}}, aluop3};
  end else begin : g_alu_trunc
    assign aluop_f = aluop3[ALUOP_W-1:0];
  end

  always_comb begin
    dec_base = '0;
    aluop3   = 3'b000;
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    case (op)
      6'b000000: begin
        dec_base.regdst = 1'b1; dec_base.regwrite = 1'b1; dec_base.memtoreg = 2'b01;
        dec_base.readdatareg = 1'b1; aluop3 = 3'b010;
        if (funct == 6'b001000) dec_base.jjr = 2'b01;
        rs_used = 1'b1; rt_used = 1'b1;
      end
      6'b001000: begin
        dec_base.alusrc = 1'b1; dec_base.regwrite = 1'b1; dec_base.memtoreg = 2'b01;
        dec_base.readdatareg = 1'b1; aluop3 = 3'b110; rs_used = 1'b1;
      end
      6'b000100, 6'b000101, 6'b000111: begin
        dec_base.branch = 1'b1; dec_base.readdatareg = 1'b1; aluop3 = 3'b001;
        dec_base.brtype = (op == 6'b000101) ? 2'b11 : (op == 6'b000111) ? 2'b01 : 2'b00;
        rs_used = 1'b1; rt_used = 1'b1;
      end
      6'b000001: begin
        dec_base.branch = 1'b1; dec_base.brtype = 2'b10; aluop3 = 3'b101; rs_used = 1'b1;
      end
      6'b100011: begin
        dec_base.alusrc = 1'b1; dec_base.regwrite = 1'b1; dec_base.memread = 1'b1;
        dec_base.readdatareg = 1'b1; aluop3 = 3'b110; rs_used = 1'b1;
      end
      6'b101011: begin
        dec_base.alusrc = 1'b1; dec_base.memwrite = 1'b1; dec_base.readdatareg = 1'b1;
        aluop3 = 3'b110; rs_used = 1'b1; rt_used = 1'b1;
      end
      6'b000010: begin
        dec_base.readdatareg = 1'b1; aluop3 = 3'b010; dec_base.jjr = 2'b10;
      end
      6'b000011: begin
        dec_base.regwrite = 1'b1; dec_base.memtoreg = 2'b11; dec_base.jal = 1'b1;
        dec_base.jjr = 2'b10; dec_base.readdatareg = 1'b1; aluop3 = 3'b010;
      end
      default: dec_base.illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec       = dec_base;
    dec.aluop = aluop_f;
    dec.rs    = rs_f;
    dec.rt    = rt_f;
    dec.rd    = rd_f;
  end

  assign hazard = valid_q & entry_q.memread & bus.id_valid_i & (entry_q.rt != '0) &
                  ((rs_used & (entry_q.rt == rs_f)) | (rt_used & (entry_q.rt == rt_f)));
  assign advance = ~valid_q | bus.ex_ready_i;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
      entry_d = '0;
    end else if (advance) begin
      if (hazard) begin
        valid_d = 1'b0;
        entry_d = '0;
      end else begin
        valid_d = bus.id_valid_i;
        entry_d = bus.id_valid_i ? dec : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign bus.id_ready_o       = bus.flush_i | (advance & ~hazard);
  assign bus.hazard_o         = hazard;
  assign bus.ex_valid_o       = valid_q;
  assign bus.ex_regdst_o      = entry_q.regdst;
  assign bus.ex_alusrc_o      = entry_q.alusrc;
  assign bus.ex_branch_o      = entry_q.branch;
  assign bus.ex_memread_o     = entry_q.memread;
  assign bus.ex_memwrite_o    = entry_q.memwrite;
  assign bus.ex_regwrite_o    = entry_q.regwrite;
  assign bus.ex_readdatareg_o = entry_q.readdatareg;
  assign bus.ex_jal_o         = entry_q.jal;
  assign bus.ex_aluop_o       = entry_q.aluop;
  assign bus.ex_brtype_o      = entry_q.brtype;
  assign bus.ex_memtoreg_o    = entry_q.memtoreg;
  assign bus.ex_jjr_o         = entry_q.jjr;
  assign bus.ex_rs_o          = entry_q.rs;
  assign bus.ex_rt_o          = entry_q.rt;
  assign bus.ex_rd_o          = entry_q.rd;
  assign bus.ex_illegal_o     = entry_q.illegal;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.id_valid_i & ~bus.id_ready_o) stall_cnt_d = stall_cnt_q + 32'd1;
    if (~bus.flush_i & advance & hazard) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: directed scenarios then randomized traffic against
// an instruction-level model that remembers which instruction sits in EX.
module tb_id_ex_ctrl_stage;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  id_ex_ctrl_stage_if #(.REG_AW(5), .ALUOP_W(3)) bus ();

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
  id_ex_ctrl_stage #(.REG_AW(5), .ALUOP_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );
`else
  id_ex_ctrl_stage #(.REG_AW(5), .ALUOP_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
`endif

  logic [17:0] obs_ctrl;
  logic [14:0] obs_regs;
  assign obs_ctrl = {bus.ex_regdst_o, bus.ex_alusrc_o, bus.ex_branch_o, bus.ex_memread_o,
                     bus.ex_memwrite_o, bus.ex_regwrite_o, bus.ex_readdatareg_o, bus.ex_jal_o,
                     bus.ex_aluop_o, bus.ex_brtype_o, bus.ex_memtoreg_o, bus.ex_jjr_o,
                     bus.ex_illegal_o};
  assign obs_regs = {bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o};

  // Model: the instruction currently held in EX (if any) plus expected counters.
  logic        m_valid;
  logic [31:0] m_instr;
  int unsigned m_stall, m_bubble;

  // Arguments follow the decode table column order.
  function automatic logic [17:0] mk(input logic regdst, alusrc, regwrite, branch,
                                     input logic [1:0] brtype, input logic memread, memwrite,
                                     input logic [1:0] memtoreg, input logic rdr,
                                     input logic [2:0] aluop, input logic jal,
                                     input logic [1:0] jjr, input logic ill);
    return {regdst, alusrc, branch, memread, memwrite, regwrite, rdr, jal,
            aluop, brtype, memtoreg, jjr, ill};
  endfunction

  function automatic logic [17:0] ref_ctrl(input logic [31:0] ins);
    logic [1:0] jr;
    jr = (ins[5:0] == 6'b001000) ? 2'b01 : 2'b00;
    case (ins[31:26])
      6'b000000: return mk(1,0,1,0,2'b00,0,0,2'b01,1,3'b010,0,jr,0);
      6'b001000: return mk(0,1,1,0,2'b00,0,0,2'b01,1,3'b110,0,2'b00,0);
      6'b000100: return mk(0,0,0,1,2'b00,0,0,2'b00,1,3'b001,0,2'b00,0);
      6'b000101: return mk(0,0,0,1,2'b11,0,0,2'b00,1,3'b001,0,2'b00,0);
      6'b000111: return mk(0,0,0,1,2'b01,0,0,2'b00,1,3'b001,0,2'b00,0);
      6'b000001: return mk(0,0,0,1,2'b10,0,0,2'b00,0,3'b101,0,2'b00,0);
      6'b100011: return mk(0,1,1,0,2'b00,1,0,2'b00,1,3'b110,0,2'b00,0);
      6'b101011: return mk(0,1,0,0,2'b00,0,1,2'b00,1,3'b110,0,2'b00,0);
      6'b000010: return mk(0,0,0,0,2'b00,0,0,2'b00,1,3'b010,0,2'b10,0);
      6'b000011: return mk(0,0,1,0,2'b00,0,0,2'b11,1,3'b010,1,2'b10,0);
      default:   return mk(0,0,0,0,2'b00,0,0,2'b00,0,3'b000,0,2'b00,1);
    endcase
  endfunction

  function automatic logic reads_rs(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h01};
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h2B, 6'h04, 6'h05, 6'h07};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check comb and registered outputs, advance the model.
  task automatic cyc(input logic [31:0] ins, input logic v, input logic fl, input logic rdy,
                     output logic acc);
    logic haz, exp_rdy;
    logic [4:0] dst;
    bus.instr_i = ins; bus.id_valid_i = v; bus.flush_i = fl; bus.ex_ready_i = rdy;
    #1;
    dst = m_instr[20:16];
    haz = m_valid && (m_instr[31:26] == 6'b100011) && (dst != 5'd0) && v &&
          ((reads_rs(ins[31:26]) && ins[25:21] == dst) ||
           (reads_rt(ins[31:26]) && ins[20:16] == dst));
    exp_rdy = fl || ((!m_valid || rdy) && !haz);
    chk("ex_valid", bus.ex_valid_o, m_valid);
    chk("ex_ctrl", obs_ctrl, m_valid ? ref_ctrl(m_instr) : 18'd0);
    if (m_valid) chk("ex_regs", obs_regs, {m_instr[25:21], m_instr[20:16], m_instr[15:11]});
    chk("hazard", bus.hazard_o, haz);
    chk("id_ready", bus.id_ready_o, exp_rdy);
`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
    acc = exp_rdy;
    @(posedge clk_i);
    if (v && !exp_rdy) m_stall++;
    if (haz && !fl && rdy) m_bubble++;
    if (fl) m_valid = 1'b0;
    else if (m_valid && !rdy) begin end
    else if (haz) m_valid = 1'b0;
    else begin m_valid = v; m_instr = ins; end
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [31:0] ins, output int n);
    logic acc;
    logic done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      cyc(ins, 1'b1, 1'b0, 1'b1, acc);
      n++;
      done = acc;
    end
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
    $display("txn instr=%08h cycles=%0d", ins, n);
  endtask

  task automatic do_reset();
    #3 rst_i = 1'b0;
    #1;
    chk("rst_valid", bus.ex_valid_o, 1'b0);
    chk("rst_ctrl", obs_ctrl, 18'd0);
    chk("rst_regs", obs_regs, 15'd0);
    chk("rst_hazard", bus.hazard_o, 1'b0);
`ifdef ID_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_bubble", bubble_cnt, 32'd0);
`endif
    m_valid = 1'b0; m_instr = 32'd0; m_stall = 0; m_bubble = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic acc;
    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h08, 6'h04, 6'h05, 6'h07,
                             6'h01, 6'h23, 6'h23, 6'h2B, 6'h03, 6'h3F};
    rst_i = 1'b0;
    bus.instr_i = 32'd0; bus.id_valid_i = 1'b0; bus.flush_i = 1'b0; bus.ex_ready_i = 1'b1;
    m_valid = 1'b0; m_instr = 32'd0; m_stall = 0; m_bubble = 0;
    @(negedge clk_i); @(negedge clk_i);
    chk("init_valid", bus.ex_valid_o, 1'b0);
    chk("init_ctrl", obs_ctrl, 18'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Reset mid-stream, then add $3,$1,$2.
    issue(32'h2025_0007, n);
    do_reset();
    issue(32'h0022_1820, n);
    chk("add_regwrite", bus.ex_regwrite_o, 1'b1);
    chk("add_memtoreg", bus.ex_memtoreg_o, 2'b01);
    chk("add_rd", bus.ex_rd_o, 5'd3);

    // Load-use: one bubble; lw $0 never stalls.
    issue(32'h8C22_0000, n);
    issue(32'h0044_1820, n);
    chk("loaduse_cycles", n, 2);
    issue(32'h8C20_0000, n);
    issue(32'h0000_1820, n);
    chk("lw_r0_cycles", n, 1);

    // Backpressure for three cycles, then release.
    issue(32'h2025_0007, n);
    repeat (3) cyc(32'h0022_1820, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_rd_held", bus.ex_rt_o, 5'd5);
    issue(32'h0022_1820, n);
    chk("bp_release_cycles", n, 1);

    // Flush wins over hazard and backpressure.
    issue(32'h8C22_0000, n);
    cyc(32'h0044_1820, 1'b1, 1'b1, 1'b0, acc);
    chk("flush_accept", acc, 1'b1);
    chk("flush_valid", bus.ex_valid_o, 1'b0);

    // Jumps and illegal opcode.
    issue(32'h0C00_0010, n);
    chk("jal_jal", bus.ex_jal_o, 1'b1);
    chk("jal_jjr", bus.ex_jjr_o, 2'b10);
    chk("jal_memtoreg", bus.ex_memtoreg_o, 2'b11);
    issue(32'h03E0_0008, n);
    chk("jr_jjr", bus.ex_jjr_o, 2'b01);
    issue(32'hFC00_0000, n);
    chk("ill_flag", bus.ex_illegal_o, 1'b1);
    chk("ill_regwrite", bus.ex_regwrite_o, 1'b0);

    // Three load-use pairs plus two backpressured cycles.
    do_reset();
    repeat (3) begin
      issue(32'h8C22_0000, n);
      issue(32'h0044_1820, n);
    end
    repeat (2) cyc(32'h0022_1820, 1'b1, 1'b0, 1'b0, acc);
    cyc(32'h0, 1'b0, 1'b0, 1'b1, acc);
`ifdef ID_STALL_CNT_EN
    chk("cnt_bubble3", bubble_cnt, 32'd3);
    chk("cnt_stall5", stall_cnt, 32'd5);
`endif

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [5:0]  op;
      op  = ops[$urandom_range(0, 11)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), 6'($urandom)};
      if (op == 6'h00) ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
      if (i == 200) do_reset();
      cyc(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Registered successor to the combinational main decoder: decodes the IF/ID instruction and captures control plus register indices into the ID/EX pipeline register.
- Adds valid/ready flow control, load-use hazard interlock with bubble insertion, branch flush and illegal-opcode flagging.
- Sits between the IF/ID register and the EX stage of the pipelined MIPS core.

Parameters:
- REG_AW, 5, register-index width.
- ALUOP_W, 3, ALU_op field width; encodings are zero-extended when wider than 3.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- instr_i  in  32  IF/ID instruction.
- id_valid_i  in  1  IF/ID holds a valid instruction.
- id_ready_o  out  1  ID consumes instr_i this cycle.
- flush_i  in  1  taken branch/jump resolved downstream; squash the younger instructions.
- ex_ready_i  in  1  EX accepts the ID/EX entry.
- ex_valid_o  out  1  ID/EX entry valid.
- ex_regdst_o, ex_alusrc_o, ex_branch_o, ex_memread_o, ex_memwrite_o, ex_regwrite_o, ex_readdatareg_o, ex_jal_o  out  1 each  registered control.
- ex_aluop_o  out  ALUOP_W  ALU op.
- ex_brtype_o  out  2  branch type.
- ex_memtoreg_o  out  2  writeback select: 00 mem, 01 ALU, 11 link.
- ex_jjr_o  out  2  jump type: 00 none, 01 jr, 10 j/jal.
- ex_rs_o, ex_rt_o, ex_rd_o  out  REG_AW each  register indices; instr fields zero-extended or truncated to REG_AW.
- ex_illegal_o  out  1  entry carries an unknown opcode.
- hazard_o  out  1  combinational load-use stall indicator.

Behaviour:
- Reset: all ex_* outputs are 0 and ex_valid_o is 0 while rst_i=0, asynchronously. hazard_o is 0 during reset because ex_valid_o is 0.
- Decode table (op -> regdst, alusrc, regwrite, branch, brtype, memread, memwrite, memtoreg, readdatareg, aluop, jal, jjr):
  - R-type 000000 -> 1,0,1,0,00,0,0,01,1,010,0,00; jjr=01 when funct=001000.
  - addi 001000 -> 0,1,1,0,00,0,0,01,1,110,0,00.
  - beq 000100 -> 0,0,0,1,00,0,0,00,1,001,0,00.
  - bne 000101 -> as beq with brtype=11.
  - bgt 000111 -> as beq with brtype=01.
  - bgez 000001 -> branch=1, brtype=10, readdatareg=0, aluop=101; all other controls 0.
  - lw 100011 -> 0,1,1,0,00,1,0,00,1,110,0,00.
  - sw 101011 -> 0,1,0,0,00,0,1,00,1,110,0,00.
  - j 000010 -> all 0 except readdatareg=1, aluop=010, jjr=10.
  - jal 000011 -> regwrite=1, memtoreg=11, jal=1, jjr=10, readdatareg=1, aluop=010; all other controls 0.
  - Any other opcode -> all controls 0, ex_illegal_o=1.
- Register-use flags:
  - rs_used: R-type, addi, lw, sw, beq, bne, bgt, bgez.
  - rt_used: R-type, sw, beq, bne, bgt.
- hazard_o = ex_valid_o & ex_memread_o & id_valid_i & (ex_rt_o != 0) & ((rs_used & ex_rt_o == rs) | (rt_used & ex_rt_o == rt)).
- advance = ~ex_valid_o | ex_ready_i.
- id_ready_o = advance & ~hazard_o, or 1 when flush_i=1.
- Clocked update, priority high to low:
  1. flush_i: ex_valid_o<=0 and all controls <=0.
  2. ~advance: hold every register.
  3. hazard_o: load a bubble (ex_valid_o<=0, controls 0).
  4. Otherwise: load the decoded instr_i, with ex_valid_o<=id_valid_i. Controls are forced to 0 when id_valid_i=0.
- Latency: 1 cycle from the ID accept edge to ex_* outputs.
- A load-use hazard costs exactly one bubble. After the bubble, EX no longer holds a lw, so the hazard clears.
- flush_i coincident with hazard or backpressure: the flush wins, and the IF/ID instruction is treated as consumed and discarded.
- A reset deasserted mid-stream resumes with an empty ID/EX register.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cnt_o increments every cycle with id_valid_i & ~id_ready_o.
  - bubble_cnt_o increments on each hazard bubble insertion.
  - Both are cleared by rst_i and wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset: rst_i=0 mid-run -> ex_valid_o=0 and all ex_* outputs 0 immediately; after release, add $3,$1,$2 (0x00221820) -> next edge ex_regwrite_o=1, ex_memtoreg_o=01, ex_rd_o=3.
- Load-use: lw $2,0($1) then add $3,$2,$4 -> hazard_o=1 for one cycle, one bubble (ex_valid_o=0), then add issues; lw $0 followed by a consumer of $0 -> no stall.
- Backpressure: ex_ready_i=0 with ex_valid_o=1 for 3 cycles -> ex_* stable, id_ready_o=0; on release the next instruction loads.
- Flush priority: flush_i=1 during a load-use hazard with ex_ready_i=0 -> ex_valid_o=0 next edge, id_ready_o=1.
- Jumps and illegal: jal 0x0C000010 -> ex_jal_o=1, ex_jjr_o=10, ex_memtoreg_o=11; jr $31 -> ex_jjr_o=01; opcode 111111 -> ex_illegal_o=1, ex_regwrite_o=0.
- ID_STALL_CNT_EN: 3 load-use pairs plus 2 backpressure cycles with id_valid_i=1 -> bubble_cnt_o=3, stall_cnt_o=5.
